// File: rtl/backing_mem_responder.sv
// Line-oriented main-memory responder: 4-beat reads after a fixed latency, 4-beat byte-masked writes.
// Define MEM_OOR_CHECK_EN to flag (and neutralise) requests whose address exceeds the array.
module backing_mem_responder #(
  parameter int DATA_BITS    = 128,
  parameter int ADDR_BITS    = 28,
  parameter int TAG_BITS     = 5,
  parameter int DEPTH_LOG2   = 14,
  parameter int READ_LATENCY = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic [1:0]             mem_req_data_offset,
  output logic                   mem_resp_valid,
  output logic [TAG_BITS-1:0]    mem_resp_tag,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   err_oor
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int LINE_BITS = DEPTH_LOG2 - 2;
  localparam int LAT_BITS  = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RLAT, S_RRESP} state_t;

  state_t                 r_state;
  logic [LINE_BITS-1:0]   r_line;
  logic [TAG_BITS-1:0]    r_tag;
  logic [1:0]             r_beat;
  logic [LAT_BITS-1:0]    r_lat;
  logic                   r_resp_valid;
  logic [TAG_BITS-1:0]    r_resp_tag;
  logic [DATA_BITS-1:0]   r_resp_data;

  // Contents survive reset; a harness may preload this array.
  logic [DATA_BITS-1:0]   r_ram [0:2**DEPTH_LOG2-1];

  logic                   w_req_fire;
  logic                   w_beat_fire;
  logic                   w_wr_en;
  logic                   w_rd_zero;
  logic [DEPTH_LOG2-1:0]  w_wr_idx;
  logic [DEPTH_LOG2-1:0]  w_rd_idx;

  assign mem_req_ready      = (r_state == S_IDLE);
  assign mem_req_data_ready = (r_state == S_WDATA);
  assign w_req_fire         = mem_req_valid && mem_req_ready;
  assign w_beat_fire        = mem_req_data_valid && mem_req_data_ready;
  assign w_wr_idx           = {r_line, mem_req_data_offset};
  assign w_rd_idx           = {r_line, r_beat};

  assign mem_resp_valid = r_resp_valid;
  assign mem_resp_tag   = r_resp_tag;
  assign mem_resp_data  = r_resp_data;

`ifdef MEM_OOR_CHECK_EN
  logic r_oor;
  logic r_err_oor;
  logic w_req_oor;

  // Any address bit above the line index means the line lies outside the array.
  assign w_req_oor = |mem_req_addr[ADDR_BITS-1:LINE_BITS];
  assign w_wr_en   = w_beat_fire && !r_oor;
  assign w_rd_zero = r_oor;
  assign err_oor   = r_err_oor;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_oor     <= 1'b0;
      r_err_oor <= 1'b0;
    end else if (w_req_fire) begin
      r_oor <= w_req_oor;
      if (w_req_oor) begin
        r_err_oor <= 1'b1;
      end
    end
  end
`else
  logic w_unused_addr_hi;

  // Upper address bits are dropped so line indices wrap around the array.
  assign w_unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:LINE_BITS];
  assign w_wr_en          = w_beat_fire;
  assign w_rd_zero        = 1'b0;
  assign err_oor          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < MASK_BITS; b++) begin
        if (mem_req_data_mask[b]) begin
          r_ram[w_wr_idx][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_tag        <= '0;
      r_beat       <= '0;
      r_lat        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_line <= mem_req_addr[LINE_BITS-1:0];
            r_tag  <= mem_req_tag;
            r_beat <= '0;
            if (mem_req_rw) begin
              r_state <= S_WDATA;
            end else begin
              r_lat   <= LAT_BITS'(READ_LATENCY - 1);
              r_state <= S_RLAT;
            end
          end
        end
        S_WDATA: begin
          if (w_beat_fire) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RLAT: begin
          if (r_lat == '0) begin
            r_beat  <= '0;
            r_state <= S_RRESP;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_RRESP: begin
          // Ready rises while beat 3 is on the bus, so a new request can follow immediately.
          r_resp_valid <= 1'b1;
          r_resp_tag   <= r_tag;
          r_resp_data  <= w_rd_zero ? '0 : r_ram[w_rd_idx];
          r_beat       <= r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backing_mem_responder.sv
// Directed bench for backing_mem_responder: write/read lines, masks, reset abort, back-to-back, wrap/OOR.
module tb_backing_mem_responder;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int TW = 5;
  localparam int DL = 14;
  localparam int RL = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_rw;
  logic [AW-1:0]   mem_req_addr;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_data_valid;
  logic            mem_req_data_ready;
  logic [DW-1:0]   mem_req_data_bits;
  logic [DW/8-1:0] mem_req_data_mask;
  logic [1:0]      mem_req_data_offset;
  logic            mem_resp_valid;
  logic [TW-1:0]   mem_resp_tag;
  logic [DW-1:0]   mem_resp_data;
  logic            err_oor;

  int n_vec = 0;
  int n_bad = 0;

  backing_mem_responder #(
    .DATA_BITS(DW), .ADDR_BITS(AW), .TAG_BITS(TW), .DEPTH_LOG2(DL), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_req_data_offset(mem_req_data_offset),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data), .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    int w;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_tag   = tag;
    w = 0;
    while (!mem_req_ready && w < 50) begin
      cycle();
      w++;
    end
    chk("req_ready", DW'(mem_req_ready), DW'(1));
    cycle();
    mem_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [3:0][1:0] offs,
                          input logic [3:0][DW-1:0] d, input logic [3:0][DW/8-1:0] m);
    int w;
    $display("write addr=%0h", addr);
    issue(1'b1, addr, '0);
    for (int i = 0; i < 4; i++) begin
      mem_req_data_valid  = 1'b1;
      mem_req_data_offset = offs[i];
      mem_req_data_bits   = d[i];
      mem_req_data_mask   = m[i];
      w = 0;
      while (!mem_req_data_ready && w < 50) begin
        cycle();
        w++;
      end
      chk($sformatf("data_ready_b%0d", i), DW'(mem_req_data_ready), DW'(1));
      cycle();
    end
    mem_req_data_valid = 1'b0;
  endtask

  // Called one step after the accept edge; checks latency, 4 beats, tag, and the drop afterwards.
  task automatic collect(input string name, input logic [TW-1:0] tag, input logic [3:0][DW-1:0] exp);
    int k;
    k = 0;
    while (!mem_resp_valid && k < 40) begin
      cycle();
      k++;
    end
    chk({name, "_latency"}, DW'(k), DW'(RL + 1));
    chk({name, "_tag"}, DW'(mem_resp_tag), DW'(tag));
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_valid_b%0d", name, b), DW'(mem_resp_valid), DW'(1));
      chk($sformatf("%s_data_b%0d", name, b), mem_resp_data, exp[b]);
      cycle();
    end
    chk({name, "_valid_end"}, DW'(mem_resp_valid), DW'(0));
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [3:0][DW-1:0] exp);
    $display("read %s addr=%0h tag=%0h", name, addr, tag);
    issue(1'b0, addr, tag);
    collect(name, tag, exp);
  endtask

  logic [3:0][1:0]     offs_seq;
  logic [3:0][DW/8-1:0] m_all;
  logic [3:0][DW-1:0]  d1, dabcd, d3, dexp3, dz, d6;
  logic [DW-1:0]       b_word;
  int                  nb, nv, w;

  initial begin
    reset = 1'b0;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_tag = '0;
    mem_req_data_valid = 1'b0; mem_req_data_bits = '0; mem_req_data_mask = '0;
    mem_req_data_offset = '0;
    offs_seq = {2'd3, 2'd2, 2'd1, 2'd0};
    m_all    = {4{16'hFFFF}};
    d1       = {DW'(4), DW'(3), DW'(2), DW'(1)};
    dabcd    = {{4{32'hDDDD_0004}}, {4{32'hCCCC_0003}}, {4{32'hBBBB_0002}}, {4{32'hAAAA_0001}}};
    dz       = '0;
    repeat (3) cycle();

    chk("rst_resp_valid", DW'(mem_resp_valid), DW'(0));
    chk("rst_resp_tag", DW'(mem_resp_tag), DW'(0));
    chk("rst_resp_data", mem_resp_data, '0);
    chk("rst_err_oor", DW'(err_oor), DW'(0));
    chk("rst_data_ready", DW'(mem_req_data_ready), DW'(0));
    reset = 1'b1;
    cycle();

    // Line 1 holds 1..4, then read it back.
    do_write(28'd1, offs_seq, d1, m_all);
    do_read("t1", 28'd1, 5'd3, d1);

    do_write(28'd2, offs_seq, dabcd, m_all);
    do_read("t2", 28'd2, 5'd1, dabcd);

    // Only byte 0 of beat 1 changes; other beats go in with empty masks.
    d3 = {{DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}};
    do_write(28'd2, {2'd3, 2'd2, 2'd0, 2'd1}, d3, {16'h0000, 16'h0000, 16'h0000, 16'h0001});
    b_word = {4{32'hBBBB_0002}};
    b_word[7:0] = 8'hFF;
    dexp3 = dabcd;
    dexp3[1] = b_word;
    do_read("t3", 28'd2, 5'd2, dexp3);

    // Reset in the middle of the read latency.
    $display("read t4a addr=1 tag=7 (aborted by reset)");
    issue(1'b0, 28'd1, 5'd7);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("t4_resp_data_rst", mem_resp_data, '0);
    chk("t4_resp_tag_rst", DW'(mem_resp_tag), DW'(0));
    chk("t4_req_ready", DW'(mem_req_ready), DW'(1));
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (mem_resp_valid) nv++;
      cycle();
    end
    chk("t4_no_resp", DW'(nv), DW'(0));
    do_read("t4b", 28'd1, 5'd4, d1);

    // Stray write beats in IDLE / during a read; request held high across the read.
    $display("read t5a addr=1 tag=5 with held request and stray data beats");
    mem_req_data_valid  = 1'b1;
    mem_req_data_offset = 2'd0;
    mem_req_data_bits   = {DW{1'b1}};
    mem_req_data_mask   = 16'hFFFF;
    repeat (2) cycle();
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'd1; mem_req_tag = 5'd5;
    chk("t5_ready_first", DW'(mem_req_ready), DW'(1));
    cycle();
    mem_req_addr = 28'd2; mem_req_tag = 5'd6;
    nb = 0;
    w = 0;
    while (w < 40) begin
      if (mem_resp_valid) begin
        chk($sformatf("t5a_data_b%0d", nb), mem_resp_data, d1[nb[1:0]]);
        chk($sformatf("t5a_tag_b%0d", nb), DW'(mem_resp_tag), DW'(5));
        nb++;
      end
      if (mem_req_ready) break;
      cycle();
      w++;
    end
    chk("t5_accept_after_beat3", DW'(nb), DW'(4));
    cycle();
    mem_req_valid = 1'b0;
    mem_req_data_valid = 1'b0;
    $display("read t5b addr=2 tag=6 (back-to-back)");
    collect("t5b", 5'd6, dexp3);

`ifdef MEM_OOR_CHECK_EN
    d6 = dz;
`else
    d6 = d1;
`endif
    do_read("t6", 28'(2**(DL-2) + 1), 5'd9, d6);
`ifdef MEM_OOR_CHECK_EN
    chk("t6_err_oor", DW'(err_oor), DW'(1));
`else
    chk("t6_err_oor", DW'(err_oor), DW'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
